// File: rtl/serial_adder_32.sv
// serial_adder_32: multi-cycle bit-serial adder, s = x + y + cin.
// One BITS_PER_CYCLE-wide full-adder slice is reused for WIDTH/BITS_PER_CYCLE
// RUN cycles under a start/busy/done handshake.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed-overflow
// output (ovf) that is valid together with done.
module serial_adder_32 #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N   = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
            $error("serial_adder_32: BITS_PER_CYCLE must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [WIDTH-1:0]        x_reg;
    logic [WIDTH-1:0]        y_reg;
    logic [WIDTH-1:0]        sum_reg;
    logic                    carry;
    logic [CW-1:0]           cnt;

    logic [BITS_PER_CYCLE:0] slice_res;
    logic [WIDTH-1:0]        sum_next;
`ifdef SERIAL_ADD_OVF_EN
    logic                    ovf_next;
`endif

    // Adder slice: low bits of both operands plus the running carry; the slice
    // sum is inserted at the top of the sum register as it shifts right.
    // Shift-and-OR form keeps BITS_PER_CYCLE == WIDTH legal (no empty part-select).
    always_comb begin
        slice_res = {1'b0, x_reg[BITS_PER_CYCLE-1:0]}
                  + {1'b0, y_reg[BITS_PER_CYCLE-1:0]}
                  + {{BITS_PER_CYCLE{1'b0}}, carry};
        sum_next  = (sum_reg >> BITS_PER_CYCLE)
                  | (WIDTH'(slice_res[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));
`ifdef SERIAL_ADD_OVF_EN
        // carry into the MSB equals x_msb ^ y_msb ^ sum_msb; XOR with carry out
        ovf_next  = slice_res[BITS_PER_CYCLE]
                  ^ x_reg[BITS_PER_CYCLE-1] ^ y_reg[BITS_PER_CYCLE-1]
                  ^ slice_res[BITS_PER_CYCLE-1];
`endif
    end

    // Control FSM and datapath registers; outputs are registered and only
    // s/cout(/ovf) update on the final RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x_reg   <= '0;
            y_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_reg <= x;
                        y_reg <= y;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    x_reg   <= x_reg >> BITS_PER_CYCLE;
                    y_reg   <= y_reg >> BITS_PER_CYCLE;
                    sum_reg <= sum_next;
                    carry   <= slice_res[BITS_PER_CYCLE];
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s     <= sum_next;
                        cout  <= slice_res[BITS_PER_CYCLE];
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= ovf_next;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_32.sv
// Testbench for serial_adder_32: two instances (1 and 8 bits per cycle),
// random and directed operations, scoreboard queues popped by done monitors.
module tb_serial_adder_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start8 = 1'b0;
    logic [31:0] x1 = '0, y1 = '0, x8 = '0, y8 = '0;
    logic        cin1 = 1'b0, cin8 = 1'b0;
    logic        busy1, done1, cout1, busy8, done8, cout8;
    logic [31:0] s1, s8;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf1, ovf8;
`endif

    serial_adder_32 #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .cin(cin1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_adder_32 #(.WIDTH(32), .BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          de;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    int   checks = 0;
    int   passed = 0;
    int   dones1 = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: plain 33-bit unsigned sum and signed range test for overflow
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input int de);
        exp_t        e;
        logic [32:0] r;
        longint      sr;
        r    = {1'b0, a} + {1'b0, b} + {32'd0, c};
        sr   = longint'($signed(a)) + longint'($signed(b)) + (c ? 64'sd1 : 64'sd0);
        e.s  = r[31:0];
        e.c  = r[32];
        e.o  = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
        e.de = de;
        return e;
    endfunction

    // Monitor for the 1-bit-per-cycle instance
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && done1) begin
            dones1++;
            if (q1.size() == 0) check("unexpected_done1", 1, 0);
            else begin
                e = q1.pop_front();
                check("s1", s1, e.s);
                check("cout1", cout1, e.c);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf1", ovf1, e.o);
`endif
                check("latency1", edges, e.de);
                check("busy_at_done1", busy1, 0);
            end
        end
    end

    // Monitor for the 8-bits-per-cycle instance
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && done8) begin
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                check("s8", s8, e.s);
                check("cout8", cout8, e.c);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf8", ovf8, e.o);
`endif
                check("latency8", edges, e.de);
            end
        end
    end

    // Called at a negedge when dut1 can accept; returns one negedge later
    task automatic go1(input logic [31:0] a, input logic [31:0] b, input logic c);
        x1 = a; y1 = b; cin1 = c; start1 = 1'b1;
        q1.push_back(model(a, b, c, edges + 1 + 32));
        @(negedge clk);
        start1 = 1'b0;
        x1 = $urandom; y1 = $urandom; cin1 = ($urandom_range(1, 0) == 1);
        check("busy1_after_start", busy1, 1);
    endtask

    task automatic go8(input logic [31:0] a, input logic [31:0] b, input logic c);
        x8 = a; y8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(model(a, b, c, edges + 1 + 4));
        @(negedge clk);
        start8 = 1'b0;
        x8 = $urandom; y8 = $urandom; cin8 = ($urandom_range(1, 0) == 1);
        check("busy8_after_start", busy8, 1);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!done1 && n < 100) begin @(negedge clk); n++; end
        if (!done1) check("timeout1", 0, 1);
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!done8 && n < 100) begin @(negedge clk); n++; end
        if (!done8) check("timeout8", 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        repeat (2) @(negedge clk);
        check("rst_s", s1, 0);
        check("rst_cout", cout1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        rst = 1'b0;
        @(negedge clk);

        go1(32'h0000_0005, 32'h0000_0003, 1'b0); wait_done1(); @(negedge clk);
        go1(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_done1();
        // back-to-back: start on the done cycle
        go1(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_done1(); @(negedge clk);
        go1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done1(); @(negedge clk);

        // start pulses during RUN must be ignored
        go1($urandom, $urandom, 1'b0);
        repeat (3) @(negedge clk);
        start1 = 1'b1; x1 = $urandom; y1 = $urandom;
        repeat (2) @(negedge clk);
        start1 = 1'b0;
        check("busy1_ignored_start", busy1, 1);
        wait_done1(); @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            go1($urandom, $urandom, ($urandom_range(1, 0) == 1));
            wait_done1();
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);

        // s holds during RUN, then async reset mid-RUN aborts without done
        go1(32'd1, 32'd1, 1'b0); wait_done1(); @(negedge clk);
        go1($urandom, $urandom, 1'b0);
        repeat (9) @(negedge clk);
        check("s_hold_run1", s1, 2);
        #2 rst = 1'b1;
        #1;
        check("abort_s", s1, 0);
        check("abort_cout", cout1, 0);
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        q1.delete(q1.size() - 1);
        @(negedge clk);
        rst = 1'b0;
        n0 = dones1;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", dones1 - n0, 0);

        go8(32'h1234_5678, 32'h8765_4321, 1'b1); wait_done8(); @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            go8($urandom, $urandom, ($urandom_range(1, 0) == 1));
            wait_done8();
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        check("q1_empty", q1.size(), 0);
        check("q8_empty", q8.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
